// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: three requester ports plus the memory port.
// master: the arbiter's view (it drives grants, read returns and the memory bus).
// slave:  the surroundings' view (requesters and the memory itself).
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [2:0]      req;
  logic [2:0]      req_we;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  modport master (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter in front of a single-port memory: data port (0), instruction
// fetch (1), loader/DMA (2). Each access is issued in a one-cycle ACCESS state;
// reads then wait RD_LAT cycles and the memory data is passed straight through
// to the granted requester.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2 instead of
// round-robin (the round-robin pointer is then removed).
module mem_port_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 2
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;

  localparam logic [2:0] RdLatM1 = 3'(RD_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    pick;
  logic [2:0]    win_onehot;
  logic          rd_done;

`ifndef ARB_FIXED_PRIO_EN
  logic [1:0]    last_q, last_d;
`endif

  // Winner selection among the currently requesting ports
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    if (bus.req[0])      pick = 2'd0;
    else if (bus.req[1]) pick = 2'd1;
    else                 pick = 2'd2;
`else
    // Search starts one past the last granted port
    case (last_q)
      2'd0:    pick = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
      default: pick = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
    endcase
`endif
  end

  // Access sequencing: latch winner in IDLE, issue in ACCESS, count down in WAIT
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d = StAccess;
          win_d   = pick;
          // Fetch port is read-only regardless of its we bit
          we_d    = (pick == 2'd1) ? 1'b0 : bus.req_we[pick];
          addr_d  = bus.req_addr[pick*AW +: AW];
          wdata_d = bus.req_wdata[pick*DW +: DW];
        end
      end
      StAccess: begin
`ifndef ARB_FIXED_PRIO_EN
        last_d = win_q;
`endif
        if (we_q) begin
          state_d = StIdle;
        end else begin
          state_d = StWait;
          cnt_d   = RdLatM1;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      win_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 3'd0;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= 2'd2;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  // Outputs decoded from state so reset clears them immediately
  always_comb begin
    win_onehot    = 3'b001 << win_q;
    rd_done       = (state_q == StWait) && (cnt_q == 3'd0);
    bus.gnt       = (state_q == StAccess) ? win_onehot : 3'b000;
    bus.rvalid    = rd_done ? win_onehot : 3'b000;
    bus.rdata     = rd_done ? bus.mem_rdata : '0;
    bus.busy      = (state_q != StIdle);
    bus.mem_en    = (state_q == StAccess);
    bus.mem_we    = (state_q == StAccess) && we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
  end

endmodule
